// File: rtl/regbank_8x64.sv
// Eight-entry writeback register bank fed by a one-hot decoder enable.
// Two combinational read ports with write-through bypass; sticky multi-hot error flag.
module regbank_8x64 #(
  parameter int WIDTH     = 64,
  parameter int ZERO_LAST = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       wr_en_onehot,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [2:0]       rd_addr_a,
  input  logic [2:0]       rd_addr_b,
  input  logic             err_clear,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             onehot_err,
  output logic [15:0]      wr_count
);

  typedef enum logic [1:0] {
    EN_NONE  = 2'd0,
    EN_ONE   = 2'd1,
    EN_MULTI = 2'd2
  } en_class_e;

  localparam logic [2:0] LAST_IDX = 3'd7;
  localparam bit         HAS_ZERO = (ZERO_LAST != 0);

  logic [WIDTH-1:0] entry [8];

  en_class_e  en_class;
  logic [2:0] wr_idx;
  logic       wr_accept;
  logic       bypass_ok;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    en_class = EN_NONE;
    if (wr_en_onehot != 8'd0) begin
      if ((wr_en_onehot & (wr_en_onehot - 8'd1)) != 8'd0) en_class = EN_MULTI;
      else                                                en_class = EN_ONE;
    end
  end

  always_comb begin
    wr_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (wr_en_onehot[i]) wr_idx = i[2:0];
    end
  end

  assign wr_accept = (en_class == EN_ONE) && !(HAS_ZERO && (wr_idx == LAST_IDX));
  assign bypass_ok = reset_n && (en_class == EN_ONE);

  // NOTE: the storage array is reset in full here because entries must read 0
  // immediately after reset; it is a small flop array, not an SRAM macro.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) entry[i] <= '0;
    end else if (wr_accept) begin
      entry[wr_idx] <= wr_data;
    end
  end

  // Set beats clear when a multi-hot enable and err_clear coincide.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      onehot_err <= 1'b0;
    end else if (en_class == EN_MULTI) begin
      onehot_err <= 1'b1;
    end else if (err_clear) begin
      onehot_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_count <= 16'd0;
    end else if (wr_accept && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [2:0] addr);
    logic [WIDTH-1:0] val;
    val = entry[addr];
    if (bypass_ok && (wr_idx == addr)) val = wr_data;
    if (HAS_ZERO && (addr == LAST_IDX)) val = '0;
    return val;
  endfunction

  assign rd_data_a = read_port(rd_addr_a);
  assign rd_data_b = read_port(rd_addr_b);

endmodule

// File: tb/tb_regbank_8x64.sv
// Self-checking bench for regbank_8x64: reference model plus expected-value queue,
// covering bypass, hardwired-zero entry, multi-hot error, mid-run reset, saturation.
module tb_regbank_8x64;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [7:0]       wr_en_onehot;
  logic [WIDTH-1:0] wr_data;
  logic [2:0]       rd_addr_a;
  logic [2:0]       rd_addr_b;
  logic             err_clear;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             onehot_err;
  logic [15:0]      wr_count;

  regbank_8x64 #(.WIDTH(WIDTH), .ZERO_LAST(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en_onehot (wr_en_onehot),
    .wr_data      (wr_data),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .err_clear    (err_clear),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .onehot_err   (onehot_err),
    .wr_count     (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [63:0] m_entry [8];
  logic        m_err;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input logic [63:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got %h expected <queued value>", got);
    end else begin
      e = sb.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  function automatic logic [63:0] model_read(input logic rst, input logic [7:0] en,
                                            input logic [63:0] d, input logic [2:0] a);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(en[i]);
    if (a == 3'd7)                  return 64'd0;
    if (rst && ones == 1 && en[a])  return d;
    return m_entry[a];
  endfunction

  // One clock cycle: drive at negedge, check combinational reads, then check
  // registered outputs just after the rising edge.
  task automatic cycle(input string tag, input logic rst, input logic [7:0] en,
                       input logic [63:0] d, input logic [2:0] a, input logic [2:0] b,
                       input logic clr, input bit do_check);
    int ones;
    int idx;
    @(negedge clk);
    reset_n      = rst;
    wr_en_onehot = en;
    wr_data      = d;
    rd_addr_a    = a;
    rd_addr_b    = b;
    err_clear    = clr;
    #1;
    if (do_check) begin
      sb.push_back('{{tag, "_rd_a"}, model_read(rst, en, d, a)});
      sb.push_back('{{tag, "_rd_b"}, model_read(rst, en, d, b)});
      pop_check(rd_data_a);
      pop_check(rd_data_b);
    end

    ones = 0;
    idx  = 0;
    for (int i = 0; i < 8; i++) if (en[i]) begin ones++; idx = i; end
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 8; i++) m_entry[i] = 64'd0;
      m_err = 1'b0;
      m_cnt = 16'd0;
    end else begin
      if (ones == 1 && idx != 7) begin
        m_entry[idx] = d;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (ones >= 2)  m_err = 1'b1;
      else if (clr)   m_err = 1'b0;
    end
    #1;
    if (do_check) begin
      sb.push_back('{{tag, "_err"}, {63'd0, m_err}});
      sb.push_back('{{tag, "_cnt"}, {48'd0, m_cnt}});
      pop_check({63'd0, onehot_err});
      pop_check({48'd0, wr_count});
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    wr_en_onehot = 8'd0;
    wr_data      = '0;
    rd_addr_a    = 3'd0;
    rd_addr_b    = 3'd0;
    err_clear    = 1'b0;
    for (int i = 0; i < 8; i++) m_entry[i] = 64'd0;
    m_err = 1'b0;
    m_cnt = 16'd0;

    cycle("reset0", 1'b0, 8'h00, 64'h0,    3'd0, 3'd7, 1'b0, 1'b1);
    cycle("reset1", 1'b0, 8'h00, 64'h0,    3'd2, 3'd5, 1'b0, 1'b1);

    // Basic writes to entries 2 and 5
    cycle("wr2",    1'b1, 8'h04, 64'hA5,   3'd2, 3'd5, 1'b0, 1'b1);
    cycle("wr5",    1'b1, 8'h20, 64'h1234, 3'd2, 3'd5, 1'b0, 1'b1);
    cycle("rd25",   1'b1, 8'h00, 64'hBAD,  3'd2, 3'd5, 1'b0, 1'b1);

    // Same-cycle bypass on both ports, then stored value
    cycle("byp3",   1'b1, 8'h08, 64'hDEAD, 3'd3, 3'd3, 1'b0, 1'b1);
    cycle("rd3",    1'b1, 8'h00, 64'h0,    3'd3, 3'd2, 1'b0, 1'b1);

    // Hardwired-zero entry 7
    cycle("wr7",    1'b1, 8'h80, 64'hFFFF, 3'd7, 3'd7, 1'b0, 1'b1);
    cycle("rd7",    1'b1, 8'h00, 64'h0,    3'd7, 3'd5, 1'b0, 1'b1);

    // Multi-hot drop, sticky error, set-beats-clear, clear
    cycle("wr0",    1'b1, 8'h01, 64'h11,   3'd0, 3'd1, 1'b0, 1'b1);
    cycle("wr1",    1'b1, 8'h02, 64'h22,   3'd0, 3'd1, 1'b0, 1'b1);
    cycle("multi",  1'b1, 8'h03, 64'h99,   3'd0, 3'd1, 1'b0, 1'b1);
    cycle("sticky", 1'b1, 8'h00, 64'h0,    3'd0, 3'd1, 1'b0, 1'b1);
    cycle("setclr", 1'b1, 8'h06, 64'h99,   3'd1, 3'd2, 1'b1, 1'b1);
    cycle("clr",    1'b1, 8'h00, 64'h0,    3'd1, 3'd2, 1'b1, 1'b1);

    // Reset mid-operation with a competing write and a pending error
    cycle("wr4",    1'b1, 8'h10, 64'h55,   3'd4, 3'd0, 1'b0, 1'b1);
    cycle("multi2", 1'b1, 8'hC0, 64'h1,    3'd4, 3'd0, 1'b0, 1'b1);
    cycle("rstwr",  1'b0, 8'h10, 64'h77,   3'd4, 3'd4, 1'b0, 1'b1);
    cycle("postrst",1'b1, 8'h00, 64'h0,    3'd4, 3'd0, 1'b0, 1'b1);

    // Saturation: drive enough accepted writes to pin the counter
    for (int n = 0; n < 65540; n++) begin
      int e;
      e = $urandom_range(0, 6);
      cycle("sat", 1'b1, 8'(1 << e), 64'(n), 3'd0, 3'd1, 1'b0, 1'b0);
    end
    cycle("satchk", 1'b1, 8'h40, 64'hCAFE, 3'd6, 3'd0, 1'b0, 1'b1);
    cycle("sathold",1'b1, 8'h02, 64'hBEEF, 3'd6, 3'd1, 1'b0, 1'b1);
    cycle("satrd",  1'b1, 8'h00, 64'h0,    3'd6, 3'd1, 1'b0, 1'b1);
    check("sat_final", {48'd0, wr_count}, 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
